turf_hold_scheduler: RTL
========================

Name: turf_hold_scheduler

Overview:
- Sequences the SURF HOLD buffers for the TURF trigger path.
- Arbitrates four trigger sources (RF L2, soft/ext, PPS1, PPS2) and allocates the next free SURF buffer in FIFO order.
- Drives the per-buffer hold mask and hands a {buffer, type, event ID} command to the CMD serializer through a valid/ready handshake.
- Frees buffers on clear-event and clear-all from the register interface (synchronized upstream); sits between the trigger/PPS sources and the HOLD/CMD fan-out.

Parameters:
- NUM_BUF, 4, number of SURF hold buffers; power of two, 2..8.
- HOLDOFF, 16, clk250 cycles between hold assertion and the command offer.
- EVID_WIDTH, 20, event ID counter width.

Ports:
- clk250_i  in  1  250 MHz trigger clock; all logic on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- rf_trig_i  in  1  RF L2 trigger, single-cycle pulse.
- ext_trig_i  in  1  soft-or-external trigger pulse.
- pps1_trig_i  in  1  PPS1 trigger pulse.
- pps2_trig_i  in  1  PPS2 trigger pulse.
- disable_i  in  1  level; blocks all new triggers.
- clr_evt_i  in  1  pulse; release the oldest held buffer.
- clr_all_i  in  1  pulse; synchronous abort and release of everything.
- evid_reset_i  in  1  pulse; event ID to 0.
- hold_o  out  NUM_BUF  per-buffer hold mask.
- cmd_valid_o  out  1  command offer.
- cmd_ready_i  in  1  serializer accepts the command.
- cmd_buf_o  out  log2(NUM_BUF)  buffer index of the command.
- cmd_type_o  out  2  trigger type: 0 RF, 1 EXT, 2 PPS1, 3 PPS2.
- cmd_evid_o  out  EVID_WIDTH  event ID of the command.
- occupancy_o  out  log2(NUM_BUF)+1  number of held buffers.
- full_o  out  1  occupancy == NUM_BUF.
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset values (rst_i high):
  - hold_o, cmd_* and occupancy_o = 0; busy_o = 0; full_o = 0.
  - Write/read pointers = 0; event ID = 0; FSM = IDLE.
- Trigger arbitration:
  - Fixed priority RF > EXT > PPS1 > PPS2.
  - A trigger is accepted only when all of: FSM == IDLE, !disable_i, !full_o, !clr_all_i.
  - Simultaneous triggers: only the winner is accepted; the others are dropped.
  - Triggers while busy or full are dropped. No queuing ever.
- Acceptance, cycle N:
  - hold_o[wr_ptr] = 1 at N+1.
  - Latch buf = wr_ptr, type = winner, evid = counter.
  - wr_ptr increments modulo NUM_BUF; event ID counter increments, wrapping at 2^EVID_WIDTH.
  - occupancy increments.
- FSM:
  - IDLE -> HOLDWAIT on accept.
  - HOLDWAIT counts HOLDOFF cycles, then -> CMD.
  - CMD: cmd_valid_o = 1; cmd_buf/type/evid stable while valid. On valid && ready -> IDLE, cmd_valid_o = 0 the next cycle.
  - Earliest next accept is one cycle after the handshake.
  - Accept-to-cmd_valid latency is HOLDOFF+1 cycles.
- clr_evt_i:
  - With occupancy > 0: clears hold_o[rd_ptr], rd_ptr increments, occupancy decrements.
  - Ignored when occupancy == 0.
  - Same-cycle accept and clear: both take effect and occupancy is unchanged.
  - Clear in the same cycle the buffer being allocated is also the oldest buffer (occupancy 0): the clear is ignored.
- clr_all_i:
  - Next cycle: hold_o = 0, pointers = 0, occupancy = 0, FSM = IDLE, cmd_valid_o = 0.
  - Any offer in progress is abandoned.
  - The event ID is not changed.
  - Takes precedence over clr_evt and triggers in the same cycle.
- evid_reset_i:
  - Counter = 0 next cycle.
  - If it coincides with an accept, the accepted event takes the old value and the counter becomes 0.
  - A command already latched is unaffected.
- disable_i mid-sequence: no effect on HOLDWAIT/CMD in progress; it only blocks new accepts.

Optional Feature:
- Macro TURF_SCHED_LOST_CNT_EN.
- When defined:
  - Adds output lost_cnt_o [15:0], saturating at 0xFFFF.
  - Incremented once per cycle in which at least one trigger is asserted but none is accepted for busy/full reasons, or a non-winning trigger is dropped. Triggers blocked by disable_i are not counted.
  - Cleared by rst_i or clr_all_i.
- When undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package turf_sched_pkg holds:
  - Trigger type encodings TRIG_RF/EXT/PPS1/PPS2.
  - FSM state encoding IDLE/HOLDWAIT/CMD.
  - Default NUM_BUF, HOLDOFF and EVID_WIDTH constants.
- One sub-module, turf_trig_prio_enc: combinational 4-input fixed-priority encoder giving valid, type and the dropped-others flag.

Test Plan:
- Single RF pulse after reset, HOLDOFF=16 → hold_o=0001 next cycle; cmd_valid_o 17 cycles after accept with buf=0, type=0, evid=0; ready held high → valid low next cycle; occupancy=1.
- Same-cycle RF+PPS2 → only RF accepted (type 0); PPS2 dropped; with TURF_SCHED_LOST_CNT_EN, lost_cnt_o=1.
- Four sequential EXT triggers, no clears (NUM_BUF=4) → hold_o=1111, full_o=1; fifth trigger dropped; one clr_evt → hold_o=1110, full_o=0; next trigger gets buf 0, evid 4.
- cmd_ready_i held low for 50 cycles during CMD → cmd_valid_o and all fields stable throughout; RF pulses in that window are dropped.
- clr_all_i asserted in CMD with occupancy 3 → next cycle hold_o=0, cmd_valid_o=0, occupancy 0, evid preserved; next trigger uses buf 0.
- Corner cases: clr_evt at occupancy 0 → no change; evid_reset coincident with accept → command carries the old evid and the following event gets 0; disable_i high → all triggers ignored and lost_cnt_o unchanged.

Source files
------------

// File: rtl/turf_sched_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// turf_sched_pkg : shared types and default constants for the HOLD scheduler
// Rev 1.0
// ----------------------------------------------------------------------------
package turf_sched_pkg;

  localparam int NUM_BUF_DEF    = 4;
  localparam int HOLDOFF_DEF    = 16;
  localparam int EVID_WIDTH_DEF = 20;

  typedef enum logic [1:0] {
    TRIG_RF   = 2'd0,
    TRIG_EXT  = 2'd1,
    TRIG_PPS1 = 2'd2,
    TRIG_PPS2 = 2'd3
  } trig_type_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLDWAIT = 2'd1,
    CMD      = 2'd2
  } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/turf_trig_prio_enc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// turf_trig_prio_enc : fixed-priority encoder RF > EXT > PPS1 > PPS2
// Rev 1.0
// ----------------------------------------------------------------------------
module turf_trig_prio_enc
  import turf_sched_pkg::*;
(
  input  logic [3:0] trig_i,
  output logic       valid_o,
  output trig_type_e type_o,
  output logic       others_o
);

  always_comb begin
    valid_o = |trig_i;
    type_o  = TRIG_RF;
    if (trig_i[0])      type_o = TRIG_RF;
    else if (trig_i[1]) type_o = TRIG_EXT;
    else if (trig_i[2]) type_o = TRIG_PPS1;
    else if (trig_i[3]) type_o = TRIG_PPS2;
    // more than one bit set means at least one loser was dropped
    others_o = (trig_i & (trig_i - 4'd1)) != 4'd0;
  end

endmodule
`default_nettype wire

// File: rtl/turf_hold_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// turf_hold_scheduler : trigger arbitration, SURF HOLD buffer allocation and
// command offer. Optional lost-trigger counter: TURF_SCHED_LOST_CNT_EN.
// Rev 1.0
// ----------------------------------------------------------------------------
module turf_hold_scheduler
  import turf_sched_pkg::*;
#(
  parameter int NUM_BUF    = NUM_BUF_DEF,
  parameter int HOLDOFF    = HOLDOFF_DEF,
  parameter int EVID_WIDTH = EVID_WIDTH_DEF
) (
  input  logic                       clk250_i,
  input  logic                       rst_i,
  input  logic                       rf_trig_i,
  input  logic                       ext_trig_i,
  input  logic                       pps1_trig_i,
  input  logic                       pps2_trig_i,
  input  logic                       disable_i,
  input  logic                       clr_evt_i,
  input  logic                       clr_all_i,
  input  logic                       evid_reset_i,
  output logic [NUM_BUF-1:0]         hold_o,
  output logic                       cmd_valid_o,
  input  logic                       cmd_ready_i,
  output logic [$clog2(NUM_BUF)-1:0] cmd_buf_o,
  output logic [1:0]                 cmd_type_o,
  output logic [EVID_WIDTH-1:0]      cmd_evid_o,
  output logic [$clog2(NUM_BUF):0]   occupancy_o,
  output logic                       full_o,
`ifdef TURF_SCHED_LOST_CNT_EN
  output logic [15:0]                lost_cnt_o,
`endif
  output logic                       busy_o
);

  localparam int PW = $clog2(NUM_BUF);
  localparam int CW = $clog2(HOLDOFF + 1);

  sched_state_e          state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW:0]           occ_q, occ_d;
  logic [NUM_BUF-1:0]    hold_q, hold_d;
  logic [EVID_WIDTH-1:0] evid_q, evid_d;
  logic [PW-1:0]         cmd_buf_q, cmd_buf_d;
  trig_type_e            cmd_type_q, cmd_type_d;
  logic [EVID_WIDTH-1:0] cmd_evid_q, cmd_evid_d;

  logic       trig_valid;
  trig_type_e win_type;
  logic       trig_others;
  logic       full;
  logic       accept;
  logic       clr_ok;

  turf_trig_prio_enc u_prio (
    .trig_i   ({pps2_trig_i, pps1_trig_i, ext_trig_i, rf_trig_i}),
    .valid_o  (trig_valid),
    .type_o   (win_type),
    .others_o (trig_others)
  );

  always_comb begin
    full   = (occ_q == (PW+1)'(NUM_BUF));
    accept = (state_q == IDLE) && !disable_i && !full && !clr_all_i && trig_valid;
    // an empty scheduler has nothing to release, even if a buffer is being allocated
    clr_ok = clr_evt_i && (occ_q != '0) && !clr_all_i;

    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    hold_d     = hold_q;
    cmd_buf_d  = cmd_buf_q;
    cmd_type_d = cmd_type_q;
    cmd_evid_d = cmd_evid_q;
    evid_d     = evid_q;

    if (clr_all_i) begin
      state_d  = IDLE;
      hold_d   = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_d    = HOLDWAIT;
            cnt_d      = CW'(HOLDOFF - 1);
            cmd_buf_d  = wr_ptr_q;
            cmd_type_d = win_type;
            cmd_evid_d = evid_q;
          end
        end
        HOLDWAIT: begin
          if (cnt_q == '0) state_d = CMD;
          else             cnt_d   = cnt_q - 1'b1;
        end
        CMD: begin
          if (cmd_ready_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      if (clr_ok) begin
        hold_d[rd_ptr_q] = 1'b0;
        rd_ptr_d         = rd_ptr_q + 1'b1;
      end
      if (accept) begin
        hold_d[wr_ptr_q] = 1'b1;
        wr_ptr_d         = wr_ptr_q + 1'b1;
      end
      occ_d = occ_q + (PW+1)'(accept) - (PW+1)'(clr_ok);
    end

    if (evid_reset_i)  evid_d = '0;
    else if (accept)   evid_d = evid_q + 1'b1;
  end

  always_ff @(posedge clk250_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      hold_q     <= '0;
      evid_q     <= '0;
      cmd_buf_q  <= '0;
      cmd_type_q <= TRIG_RF;
      cmd_evid_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      hold_q     <= hold_d;
      evid_q     <= evid_d;
      cmd_buf_q  <= cmd_buf_d;
      cmd_type_q <= cmd_type_d;
      cmd_evid_q <= cmd_evid_d;
    end
  end

`ifdef TURF_SCHED_LOST_CNT_EN
  logic [15:0] lost_q, lost_d;

  always_comb begin
    lost_d = lost_q;
    if (clr_all_i)
      lost_d = '0;
    else if (trig_valid && !disable_i && (!accept || trig_others) && (lost_q != 16'hFFFF))
      lost_d = lost_q + 16'd1;
  end

  always_ff @(posedge clk250_i or posedge rst_i) begin
    if (rst_i) lost_q <= '0;
    else       lost_q <= lost_d;
  end

  assign lost_cnt_o = lost_q;
`else
  logic unused_others;
  assign unused_others = trig_others;
`endif

  assign hold_o      = hold_q;
  assign cmd_valid_o = (state_q == CMD);
  assign cmd_buf_o   = cmd_buf_q;
  assign cmd_type_o  = cmd_type_q;
  assign cmd_evid_o  = cmd_evid_q;
  assign occupancy_o = occ_q;
  assign full_o      = full;
  assign busy_o      = (state_q != IDLE);

endmodule
`default_nettype wire
